retraso_pulso_multi: RTL and testbench
======================================

RETRASO_PULSO_MULTI -- requirements
Module: retraso_pulso_multi

Interface
REQ-001 Parameter N_CH, default 2, number of independent delay channels (1..16).
REQ-002 Parameter CNT_W, default 4, width of delay and width counters (2..16).
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 enable_i  input  1  global enable; low forces all channels idle.
REQ-006 pulso_i  input  N_CH  per-channel trigger; falling edge starts a sequence.
REQ-007 retardo_i  input  CNT_W  delay D in clock cycles, shared by all channels.
REQ-008 ancho_i  input  CNT_W  output low-pulse width W in clock cycles, shared.
REQ-009 pulso_retrasado_o  output  N_CH  per-channel active-low delayed pulse; idle high; registered.
REQ-010 ocupado_o  output  N_CH  per-channel busy flag; high when channel not IDLE; registered.

Function
REQ-011 Each channel SHALL have a private state machine with states IDLE, RETRASO and ACTIVO, plus a private CNT_W-bit down-counter, a private width register and a previous-input register pulso_q.
REQ-012 Falling edge SHALL be detected at a clock edge where pulso_q=1 and pulso_i=0; pulso_q SHALL update every cycle, including while enable_i=0.
REQ-013 In IDLE with enable_i=1, a detected edge at clock edge E0 SHALL move to RETRASO, load counter with max(D,1)-1 and capture max(W,1) into the width register.
REQ-014 In RETRASO, counter!=0 SHALL decrement; counter==0 SHALL move to ACTIVO, drive pulso_retrasado_o low and load counter with captured width-1.
REQ-015 In ACTIVO, counter!=0 SHALL decrement; counter==0 SHALL move to IDLE and drive pulso_retrasado_o high.
REQ-016 Resulting timing: output low after edge E0+D, high again after edge E0+D+W; earliest next accepted trigger at edge E0+D+W+1.
REQ-017 D=0 SHALL behave as D=1; W=0 SHALL behave as W=1.
REQ-018 retardo_i and ancho_i changes after E0 SHALL not affect the running sequence.
REQ-019 Trigger edges detected in ACTIVO SHALL be ignored; edges in RETRASO governed by REQ-027/028.
REQ-020 enable_i=0 at any clock edge SHALL put every channel in IDLE, output high, counter zero, overriding any simultaneous trigger.
REQ-021 Channels SHALL be fully independent; simultaneous triggers on several channels SHALL each start their own sequence in the same cycle.
REQ-022 Counters SHALL never wrap: decrement only from nonzero values.

Reset
REQ-023 rst_ni=0 SHALL asynchronously force all states to IDLE, counters and width registers to zero.
REQ-024 During reset pulso_retrasado_o SHALL be all-ones and ocupado_o all-zeros.
REQ-025 pulso_q SHALL reset to all-ones so an input held low through reset release is not seen as an edge.
REQ-026 Reset asserted mid-sequence SHALL abort it; no output pulse completes after release.

Configuration
REQ-027 With macro RETRASO_REDISPARO_EN defined, an edge detected in RETRASO SHALL reload counter with max(D,1)-1 and recapture width, restarting the delay from that edge.
REQ-028 Without RETRASO_REDISPARO_EN, edges detected in RETRASO SHALL be ignored and the sequence SHALL complete unchanged.

Verification
REQ-029 Scenario defaults: N_CH=2, CNT_W=4, D=4, W=14, enable_i=1; ch0 falls at E0 -> ch0 output low after E0+4, high after E0+18, ocupado_o[0] high E0..E0+17, ch1 idle.
REQ-030 D=0, W=0, single ch1 falling edge -> ch1 output low for exactly 1 cycle after E0+1.
REQ-031 ch0 second falling edge at E0+2, D=4 -> macro off: output low after E0+4; macro on: output low after E0+6, width 14 unchanged.
REQ-032 enable_i dropped at E0+8 during ACTIVO -> output high and ocupado_o low after E0+8; new edge at E0+10 with enable_i=1 restarts correctly.
REQ-033 rst_ni pulsed low mid-RETRASO with pulso_i held low through release -> outputs idle immediately, no pulse until a fresh high-to-low edge.
REQ-034 Both channels fall in the same cycle, D=15, W=15 -> identical outputs low after E0+15, high after E0+30, no counter wrap.

Source files
------------

// File: rtl/retraso_pulso_multi.sv
// Multi-channel falling-edge pulse delayer: delay D, then an active-low pulse of width W.
// Optional retrigger during the delay phase: define RETRASO_REDISPARO_EN.
module retraso_pulso_multi #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic [N_CH-1:0]  pulso_i,
  input  logic [CNT_W-1:0] retardo_i,
  input  logic [CNT_W-1:0] ancho_i,
  output logic [N_CH-1:0]  pulso_retrasado_o,
  output logic [N_CH-1:0]  ocupado_o
);

  typedef enum logic [1:0] {
    IDLE,
    RETRASO,
    ACTIVO
  } estado_t;

  localparam logic [CNT_W-1:0] UNO = CNT_W'(1);

  logic [N_CH-1:0]  pulso_q;
  logic             listo_q;
  logic [CNT_W-1:0] carga_d;
  logic [CNT_W-1:0] ancho_ef;

  // Zero delay/width behave as one cycle.
  assign carga_d  = (retardo_i == '0) ? '0 : retardo_i - UNO;
  assign ancho_ef = (ancho_i == '0) ? UNO : ancho_i;

  // listo_q masks the first cycle after reset so a held-low input is not an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pulso_q <= '1;
      listo_q <= 1'b0;
    end else begin
      pulso_q <= pulso_i;
      listo_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_canal
    estado_t          est_q, est_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ancho_q, ancho_d;
    logic             flanco;
    logic             sal_q;
    logic             ocu_q;

    assign flanco = listo_q & pulso_q[g] & ~pulso_i[g];

    always_comb begin
      est_d   = est_q;
      cnt_d   = cnt_q;
      ancho_d = ancho_q;
      if (!enable_i) begin
        est_d = IDLE;
        cnt_d = '0;
      end else begin
        unique case (est_q)
          IDLE: begin
            if (flanco) begin
              est_d   = RETRASO;
              cnt_d   = carga_d;
              ancho_d = ancho_ef;
            end
          end
          RETRASO: begin
`ifdef RETRASO_REDISPARO_EN
            if (flanco) begin
              cnt_d   = carga_d;
              ancho_d = ancho_ef;
            end else
`endif
            if (cnt_q != '0) begin
              cnt_d = cnt_q - UNO;
            end else begin
              est_d = ACTIVO;
              cnt_d = ancho_q - UNO;
            end
          end
          ACTIVO: begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - UNO;
            end else begin
              est_d = IDLE;
            end
          end
          default: begin
            est_d = IDLE;
            cnt_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        est_q   <= IDLE;
        cnt_q   <= '0;
        ancho_q <= '0;
        sal_q   <= 1'b1;
        ocu_q   <= 1'b0;
      end else begin
        est_q   <= est_d;
        cnt_q   <= cnt_d;
        ancho_q <= ancho_d;
        sal_q   <= (est_d != ACTIVO);
        ocu_q   <= (est_d != IDLE);
      end
    end

    assign pulso_retrasado_o[g] = sal_q;
    assign ocupado_o[g]         = ocu_q;
  end

endmodule

// File: tb/tb_retraso_pulso_multi.sv
// Bench for retraso_pulso_multi: timestamp model plus directed literal scenarios.
// Honours RETRASO_REDISPARO_EN when defined.
module tb_retraso_pulso_multi;
  localparam int N  = 2;
  localparam int CW = 4;
`ifdef RETRASO_REDISPARO_EN
  localparam bit REDISP = 1'b1;
`else
  localparam bit REDISP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b1;
  logic [N-1:0]  pulso = '1;
  logic [CW-1:0] ret = CW'(4);
  logic [CW-1:0] anc = CW'(14);
  logic [N-1:0]  sal;
  logic [N-1:0]  ocu;

  int tests = 0;
  int fails = 0;

  retraso_pulso_multi #(.N_CH(N), .CNT_W(CW)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .enable_i(enable),
    .pulso_i(pulso),
    .retardo_i(ret),
    .ancho_i(anc),
    .pulso_retrasado_o(sal),
    .ocupado_o(ocu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Model: each channel remembers the edge index of its sequence start plus D/W.
  logic [N-1:0] exp_sal = '1;
  logic [N-1:0] exp_ocu = '0;
  logic [N-1:0] pq = '1;
  bit           armed = 1'b0;
  int           cyc = 0;
  int           st[N];
  int           dd[N];
  int           ww[N];
  bit           vld[N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pq = '1;
      armed = 1'b0;
      for (int c = 0; c < N; c++) vld[c] = 1'b0;
      exp_sal = '1;
      exp_ocu = '0;
    end else begin
      cyc++;
      for (int c = 0; c < N; c++) begin
        bit fall, pb, pr;
        fall = armed && pq[c] && !pulso[c];
        pb = vld[c] && (cyc - 1 < st[c] + dd[c] + ww[c]);
        pr = vld[c] && (cyc - 1 < st[c] + dd[c]);
        if (!enable) vld[c] = 1'b0;
        else if (fall && (!pb || (pr && REDISP))) begin
          st[c] = cyc;
          dd[c] = (ret == 0) ? 1 : int'(ret);
          ww[c] = (anc == 0) ? 1 : int'(anc);
          vld[c] = 1'b1;
        end
        exp_ocu[c] = vld[c] && cyc < st[c] + dd[c] + ww[c];
        exp_sal[c] = !(vld[c] && cyc >= st[c] + dd[c]
                       && cyc < st[c] + dd[c] + ww[c]);
      end
      pq = pulso;
      armed = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("model_sal", 32'(sal), 32'(exp_sal));
    chk("model_ocu", 32'(ocu), 32'(exp_ocu));
  end

  task automatic lit(input int k, input int c, input int ls, input int le);
    chk($sformatf("lit_sal ch%0d k%0d", c, k), 32'(sal[c]), 32'(!(k >= ls && k < le)));
    chk($sformatf("lit_ocu ch%0d k%0d", c, k), 32'(ocu[c]), 32'(k < le));
  endtask

  task automatic idle(input string nm, input int c);
    chk({nm, "_sal"}, 32'(sal[c]), 32'd1);
    chk({nm, "_ocu"}, 32'(ocu[c]), 32'd0);
  endtask

  task automatic settle();
    @(negedge clk);
    pulso = '1;
    enable = 1'b1;
    ret = CW'(4);
    anc = CW'(14);
    repeat (40) @(negedge clk);
  endtask

  task automatic fall(input int c);
    @(negedge clk);
    pulso[c] = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    int ls;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_sal", 32'(sal), 32'(2'b11));
    chk("reset_ocu", 32'(ocu), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Basic: D=4 W=14 on ch0
    settle();
    fall(0);
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      lit(k, 0, 4, 18);
      idle("s1_ch1", 1);
    end

    // D=0 W=0 on ch1
    settle();
    ret = '0;
    anc = '0;
    fall(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      lit(k, 1, 1, 2);
    end

    // Second edge at E0+2 while delaying, then D/W changes
    settle();
    fall(0);
    ls = REDISP ? 6 : 4;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      lit(k, 0, ls, ls + 14);
      if (k == 0) pulso[0] = 1'b1;
      if (k == 1) pulso[0] = 1'b0;
      if (k == 3) begin ret = CW'(1); anc = CW'(2); end
    end

    // Enable drop at E0+8, new edge at E0+10
    settle();
    fall(0);
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      if (k < 8) lit(k, 0, 4, 18);
      else if (k < 10) idle("s4_off", 0);
      else lit(k - 10, 0, 4, 18);
      if (k == 0) pulso[0] = 1'b1;
      if (k == 7) enable = 1'b0;
      if (k == 8) enable = 1'b1;
      if (k == 9) pulso[0] = 1'b0;
    end

    // Reset mid-delay with input held low through release
    settle();
    fall(0);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 1) begin
        #2 rst_n = 1'b0;
        #1 idle("s5_inrst", 0);
      end
      if (k == 3) #2 rst_n = 1'b1;
      if (k >= 1) idle("s5_after", 0);
      else lit(k, 0, 4, 18);
    end
    settle();
    fall(0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lit(k, 0, 4, 18);
    end

    // Both channels, D=15 W=15
    settle();
    ret = CW'(15);
    anc = CW'(15);
    @(negedge clk);
    pulso = '0;
    @(posedge clk);
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      lit(k, 0, 15, 30);
      lit(k, 1, 15, 30);
    end

    // Random phase, checked by the model process
    settle();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 3) == 0) pulso[c] = ~pulso[c];
      if ($urandom_range(0, 7) == 0) ret = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) anc = CW'($urandom_range(0, 15));
      enable = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
